multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Multicycle FSM that sequences the RV64 datapath (PC, IR, register file, ALU, data memory) through FETCH/DECODE/EXEC/MEM/WB.
- Decodes opcode/funct fields from the IR and drives every datapath control strobe, one instruction at a time.
- Adds a start/run/halt handshake, an illegal-instruction trap and a retired-instruction counter for the testbench and a future debug port.

Parameters:
CNT_WIDTH, 32, width of the retired-instruction counter

Ports:
CLK  input  1  system clock, all state on rising edge
RST_N  input  1  asynchronous active-low reset
opcode  input  7  IR[6:0]
funct3  input  3  IR[14:12]
funct7  input  7  IR[31:25]
start  input  1  pulse; leaves IDLE and resets the PC
run  input  1  level; 0 pauses at the next instruction boundary
ir_load  output  1  IR load enable
reset_pc  output  1  PC synchronous clear
load_pc  output  1  PC update enable
pc_next_sel  output  1  1 = branch target (flag-qualified), 0 = PC+4
sub  output  1  ALU subtract
ULA_din2_sel  output  1  1 = immediate, 0 = rs2
RF_din_sel  output  1  1 = ALU result, 0 = memory data
WE_RF  output  1  register file write enable
WE_MEM  output  1  data memory write enable
busy  output  1  high in any state except IDLE, PAUSED, HALT, TRAP
halted  output  1  high in HALT or TRAP
illegal  output  1  high in TRAP only
retired  output  1  one-cycle pulse on instruction completion
retired_count  output  CNT_WIDTH  completed-instruction count, wraps

Behaviour:
- Reset: RST_N low asynchronously forces state to IDLE, the class register to NONE and retired_count to 0. All outputs read 0 while RST_N is low and in IDLE.
- States: IDLE, INIT, FETCH, DECODE, EXEC, MEM, WB, PAUSED, HALT, TRAP. Outputs are Moore, decoded from the state and the latched class.
- IDLE: start=1 goes to INIT; otherwise stays.
- INIT: reset_pc=1 for one cycle, then FETCH.
- FETCH: ir_load=1, then DECODE.
- DECODE: latches the class and goes to EXEC, HALT or TRAP.
  - R: opcode 0110011, funct3 000; funct7 must be 0000000 or 0100000.
  - I: opcode 0010011, funct3 000.
  - LD: opcode 0000011, funct3 011.
  - SD: opcode 0100011, funct3 011.
  - BR: opcode 1100011, funct3 not in {010, 011}.
  - SYS: opcode 1110011 goes to HALT.
  - Anything else goes to TRAP.
- sub=1 for BR and for R with funct7[5]=1; otherwise 0.
- ULA_din2_sel=1 for I, LD and SD; 0 for R and BR.
- sub and ULA_din2_sel are held constant through EXEC, MEM and WB so the ALU result and memory address stay stable.
- EXEC:
  - BR: load_pc=1, pc_next_sel=1; the instruction completes here.
  - R/I: go to WB.
  - LD/SD: go to MEM.
- MEM:
  - SD: WE_MEM=1, load_pc=1, pc_next_sel=0; the instruction completes here.
  - LD: go to WB.
- WB: WE_RF=1, RF_din_sel=1 for R/I and 0 for LD; load_pc=1, pc_next_sel=0; the instruction completes here.
- Completion:
  - retired=1 in the completing cycle; retired_count increments, wrapping from all-ones to 0.
  - Next state is FETCH if run=1, PAUSED if run=0.
- PAUSED: all strobes 0; run=1 goes to FETCH, with no PC reset.
- Latency, FETCH to retired pulse inclusive: BR 3 cycles; R, I and SD 4 cycles; LD 5 cycles.
- HALT and TRAP are sticky and can only be left by RST_N. start and run are ignored there.
- start is ignored outside IDLE. run is sampled only at completion and in PAUSED.
- At most one of WE_RF / WE_MEM is high in any cycle. load_pc is high only in a completing cycle. reset_pc and load_pc are never high together.
- Reset mid-instruction abandons the instruction immediately: no write strobe is issued and retired_count is not incremented.

Test Plan:
- Reset then start pulse, run=1, feed R-type add (0110011/000/0000000): INIT (reset_pc=1), FETCH, DECODE, EXEC, WB (WE_RF=1, RF_din_sel=1, load_pc=1, sub=0), then FETCH; retired_count=1.
- Sequence sub, addi, ld, sd, beq: sub=1 only for sub and beq; ld has WE_RF=1 with RF_din_sel=0 on its 5th cycle; sd has WE_MEM=1 on its 4th cycle; beq has pc_next_sel=1 on its 3rd cycle; retired_count=5 after 21 cycles.
- Drop run=0 during an addi EXEC: WB completes and goes to PAUSED with all strobes 0. Raise run after 10 cycles: FETCH next cycle, reset_pc stays 0.
- Feed opcode 0110011 with funct3=001: TRAP, halted=1, illegal=1, no WE_RF/WE_MEM/load_pc. A start pulse has no effect; state is held until RST_N.
- Feed opcode 1110011: HALT, halted=1, illegal=0, retired_count unchanged.
- Assert RST_N=0 asynchronously during ld MEM: outputs go to 0 before the next edge; after release, state is IDLE and retired_count=0. Force the counter to all-ones with CNT_WIDTH=4: 16 retirements wrap it to 0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for the RV64 datapath: fetch, decode, execute, memory and write-back,
// with a start/run/halt handshake, an illegal-instruction trap and a retired-instruction counter.
module multicycle_control_unit #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic                 start,
  input  logic                 run,
  output logic                 ir_load,
  output logic                 reset_pc,
  output logic                 load_pc,
  output logic                 pc_next_sel,
  output logic                 sub,
  output logic                 ULA_din2_sel,
  output logic                 RF_din_sel,
  output logic                 WE_RF,
  output logic                 WE_MEM,
  output logic                 busy,
  output logic                 halted,
  output logic                 illegal,
  output logic                 retired,
  output logic [CNT_WIDTH-1:0] retired_count
);

  localparam logic [3:0] StIdle   = 4'd0;
  localparam logic [3:0] StInit   = 4'd1;
  localparam logic [3:0] StFetch  = 4'd2;
  localparam logic [3:0] StDecode = 4'd3;
  localparam logic [3:0] StExec   = 4'd4;
  localparam logic [3:0] StMem    = 4'd5;
  localparam logic [3:0] StWb     = 4'd6;
  localparam logic [3:0] StPaused = 4'd7;
  localparam logic [3:0] StHalt   = 4'd8;
  localparam logic [3:0] StTrap   = 4'd9;

  // R-type add and sub are separate classes so the ALU subtract strobe needs no extra flag.
  localparam logic [2:0] ClsNone = 3'd0;
  localparam logic [2:0] ClsRAdd = 3'd1;
  localparam logic [2:0] ClsRSub = 3'd2;
  localparam logic [2:0] ClsI    = 3'd3;
  localparam logic [2:0] ClsLd   = 3'd4;
  localparam logic [2:0] ClsSd   = 3'd5;
  localparam logic [2:0] ClsBr   = 3'd6;

  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpI    = 7'b0010011;
  localparam logic [6:0] OpLd   = 7'b0000011;
  localparam logic [6:0] OpSd   = 7'b0100011;
  localparam logic [6:0] OpBr   = 7'b1100011;
  localparam logic [6:0] OpSys  = 7'b1110011;

  logic [3:0]           state_q, state_d;
  logic [2:0]           cls_q, cls_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic [2:0] dec_cls;
  logic       dec_halt;
  logic       complete;
  logic       in_alu;

  always_comb begin
    dec_cls  = ClsNone;
    dec_halt = 1'b0;
    case (opcode)
      OpR: begin
        if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
          dec_cls = ClsRAdd;
        end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
          dec_cls = ClsRSub;
        end
      end
      OpI: begin
        if (funct3 == 3'b000) dec_cls = ClsI;
      end
      OpLd: begin
        if (funct3 == 3'b011) dec_cls = ClsLd;
      end
      OpSd: begin
        if (funct3 == 3'b011) dec_cls = ClsSd;
      end
      OpBr: begin
        if (funct3 != 3'b010 && funct3 != 3'b011) dec_cls = ClsBr;
      end
      OpSys: dec_halt = 1'b1;
      default: dec_cls = ClsNone;
    endcase
  end

  assign complete = (state_q == StExec && cls_q == ClsBr) ||
                    (state_q == StMem && cls_q == ClsSd) ||
                    (state_q == StWb);

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    case (state_q)
      StIdle:   if (start) state_d = StInit;
      StInit:   state_d = StFetch;
      StFetch:  state_d = StDecode;
      StDecode: begin
        if (dec_halt) begin
          state_d = StHalt;
          cls_d   = ClsNone;
        end else if (dec_cls == ClsNone) begin
          state_d = StTrap;
          cls_d   = ClsNone;
        end else begin
          state_d = StExec;
          cls_d   = dec_cls;
        end
      end
      StExec: begin
        case (cls_q)
          ClsRAdd, ClsRSub, ClsI: state_d = StWb;
          ClsLd, ClsSd:           state_d = StMem;
          ClsBr:                  state_d = StExec;
          default:                state_d = StTrap;
        endcase
      end
      StMem: begin
        case (cls_q)
          ClsLd:   state_d = StWb;
          ClsSd:   state_d = StMem;
          default: state_d = StTrap;
        endcase
      end
      StWb:     state_d = StWb;
      StPaused: if (run) state_d = StFetch;
      StHalt:   state_d = StHalt;
      StTrap:   state_d = StTrap;
      default:  state_d = StIdle;
    endcase
    // Every completing state funnels through the run check at the instruction boundary.
    if (complete) state_d = run ? StFetch : StPaused;
  end

  always_comb begin
    count_d = count_q;
    if (complete) count_d = count_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      cls_q   <= ClsNone;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      count_q <= count_d;
    end
  end

  // ALU operand controls stay fixed from EXEC to completion to keep result and address stable.
  assign in_alu = (state_q == StExec) || (state_q == StMem) || (state_q == StWb);

  assign ir_load      = (state_q == StFetch);
  assign reset_pc     = (state_q == StInit);
  assign load_pc      = complete;
  assign pc_next_sel  = (state_q == StExec) && (cls_q == ClsBr);
  assign sub          = in_alu && (cls_q == ClsRSub || cls_q == ClsBr);
  assign ULA_din2_sel = in_alu && (cls_q == ClsI || cls_q == ClsLd || cls_q == ClsSd);
  assign RF_din_sel   = (state_q == StWb) && (cls_q != ClsLd);
  assign WE_RF        = (state_q == StWb);
  assign WE_MEM       = (state_q == StMem) && (cls_q == ClsSd);
  assign busy         = !(state_q == StIdle || state_q == StPaused ||
                          state_q == StHalt || state_q == StTrap);
  assign halted       = (state_q == StHalt) || (state_q == StTrap);
  assign illegal      = (state_q == StTrap);
  assign retired      = complete;
  assign retired_count = count_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized scoreboard bench: stimulus pushes per-instruction expectations, a negedge monitor
// checks strobes, latency and the retired count on every retirement pulse.
module tb_multicycle_control_unit;

  localparam int unsigned CW = 4;
  localparam int CMOD = 16;

  logic CLK, RST_N;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic start, run;
  logic ir_load, reset_pc, load_pc, pc_next_sel, sub, ULA_din2_sel, RF_din_sel;
  logic WE_RF, WE_MEM, busy, halted, illegal, retired;
  logic [CW-1:0] retired_count;
  logic [12:0] outv;

  multicycle_control_unit #(.CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RST_N(RST_N), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .start(start), .run(run), .ir_load(ir_load), .reset_pc(reset_pc), .load_pc(load_pc),
    .pc_next_sel(pc_next_sel), .sub(sub), .ULA_din2_sel(ULA_din2_sel),
    .RF_din_sel(RF_din_sel), .WE_RF(WE_RF), .WE_MEM(WE_MEM), .busy(busy), .halted(halted),
    .illegal(illegal), .retired(retired), .retired_count(retired_count)
  );

  assign outv = {ir_load, reset_pc, load_pc, pc_next_sel, sub, ULA_din2_sel, RF_din_sel,
                 WE_RF, WE_MEM, busy, halted, illegal, retired};

  typedef struct {
    logic  we_rf, rf_sel, we_mem, pc_sel, sub, src;
    int    lat;
    int    cnt;
    string name;
  } exp_t;

  exp_t sb_q[$];
  int tests = 0;
  int fails = 0;
  int model_cnt = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: invariants every cycle, scoreboard pop on every retirement.
  initial begin
    int   cyc = 0;
    int   fcyc = 0;
    logic pend = 1'b0;
    int   cexp = 0;
    exp_t e;
    forever begin
      @(negedge CLK);
      cyc++;
      if (!RST_N) begin
        pend = 1'b0;
        continue;
      end
      if (pend) begin
        chk("retired_count", int'(retired_count), cexp);
        pend = 1'b0;
      end
      chk("we_exclusive", int'(WE_RF & WE_MEM), 0);
      chk("load_pc_only_on_retire", int'(load_pc & ~retired), 0);
      chk("reset_pc_vs_load_pc", int'(reset_pc & load_pc), 0);
      if (ir_load) fcyc = cyc;
      if (retired) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_retire", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk({e.name, "_strobes"},
              int'({WE_RF, RF_din_sel, WE_MEM, load_pc, pc_next_sel, sub, ULA_din2_sel}),
              int'({e.we_rf, e.rf_sel, e.we_mem, 1'b1, e.pc_sel, e.sub, e.src}));
          chk({e.name, "_latency"}, cyc - fcyc + 1, e.lat);
          cexp = e.cnt;
          pend = 1'b1;
        end
      end
    end
  end

  task automatic wait_fetch();
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (ir_load) begin
        ok = 1'b1;
        break;
      end
    end
    chk("fetch_timeout", int'(ok), 1);
  endtask

  task automatic wait_retire();
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (retired) begin
        ok = 1'b1;
        break;
      end
    end
    chk("retire_timeout", int'(ok), 1);
  endtask

  // Drive a legal instruction of kind k while in FETCH and record what it must do.
  // k: 0 add, 1 sub, 2 addi, 3 ld, 4 sd, 5 branch
  task automatic issue_cls(input int k);
    exp_t e;
    e.we_rf = 0; e.rf_sel = 0; e.we_mem = 0; e.pc_sel = 0; e.sub = 0; e.src = 0;
    funct7 = 7'($urandom);
    case (k)
      0: begin opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0000000;
         e.name = "add"; e.lat = 4; e.we_rf = 1; e.rf_sel = 1; end
      1: begin opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0100000;
         e.name = "sub"; e.lat = 4; e.we_rf = 1; e.rf_sel = 1; e.sub = 1; end
      2: begin opcode = 7'b0010011; funct3 = 3'b000;
         e.name = "addi"; e.lat = 4; e.we_rf = 1; e.rf_sel = 1; e.src = 1; end
      3: begin opcode = 7'b0000011; funct3 = 3'b011;
         e.name = "ld"; e.lat = 5; e.we_rf = 1; e.src = 1; end
      4: begin opcode = 7'b0100011; funct3 = 3'b011;
         e.name = "sd"; e.lat = 4; e.we_mem = 1; e.src = 1; end
      default: begin
        opcode = 7'b1100011;
        funct3 = 3'($urandom);
        if (funct3 == 3'b010 || funct3 == 3'b011) funct3 = 3'b000;
        e.name = "br"; e.lat = 3; e.pc_sel = 1; e.sub = 1;
      end
    endcase
    model_cnt = (model_cnt + 1) % CMOD;
    e.cnt = model_cnt;
    sb_q.push_back(e);
  endtask

  task automatic issue_illegal(input int k);
    logic [6:0] op;
    funct7 = 7'($urandom);
    case (k)
      0: begin opcode = 7'b0110011; funct3 = 3'($urandom_range(1, 7)); funct7 = 7'b0; end
      1: begin
        opcode = 7'b0110011; funct3 = 3'b000;
        if (funct7 == 7'b0000000 || funct7 == 7'b0100000) funct7 = 7'b0000001;
      end
      2: begin opcode = 7'b0010011; funct3 = 3'($urandom_range(1, 7)); end
      3: begin opcode = 7'b0000011; funct3 = 3'($urandom_range(0, 2)); end
      4: begin opcode = 7'b0100011; funct3 = 3'($urandom_range(4, 7)); end
      5: begin opcode = 7'b1100011; funct3 = 3'($urandom_range(2, 3)); end
      default: begin
        do op = 7'($urandom);
        while (op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
               op == 7'b0100011 || op == 7'b1100011 || op == 7'b1110011);
        opcode = op;
        funct3 = 3'($urandom);
      end
    endcase
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
  task automatic do_reset();
    #2 RST_N = 1'b0;
    #1;
    chk("reset_outputs_zero", int'(outv), 0);
    chk("reset_count_zero", int'(retired_count), 0);
    sb_q.delete();
    model_cnt = 0;
    start = 1'b0;
    run = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic start_run();
    @(negedge CLK);
    chk("idle_outputs_zero", int'(outv), 0);
    start = 1'b1;
    run = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    chk("init_reset_pc", int'({reset_pc, busy, load_pc}), 3'b110);
  endtask

  // Two cycles after FETCH of a SYS/illegal word the FSM must sit in HALT or TRAP forever.
  task automatic check_stuck(input string name, input int vec);
    @(negedge CLK);
    @(negedge CLK);
    chk({name, "_outputs"}, int'(outv), vec);
    chk({name, "_count_held"}, int'(retired_count), model_cnt);
    start = 1'b1;
    run = 1'($urandom);
    @(negedge CLK);
    start = 1'b0;
    repeat (3) @(negedge CLK);
    chk({name, "_sticky"}, int'(outv), vec);
  endtask

  initial begin
    RST_N = 1'b0; start = 1'b0; run = 1'b0;
    opcode = '0; funct3 = '0; funct7 = '0;
    repeat (2) @(negedge CLK);
    chk("por_outputs_zero", int'(outv), 0);
    chk("por_count_zero", int'(retired_count), 0);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    chk("idle_without_start", int'(outv), 0);

    start_run();
    wait_fetch();
    issue_cls(0);
    for (int i = 0; i < 40; i++) begin
      wait_fetch();
      issue_cls(int'($urandom_range(0, 5)));
    end

    // Pause at the boundary after an addi, then resume without a PC reset.
    wait_fetch();
    issue_cls(2);
    @(negedge CLK);
    run = 1'b0;
    wait_retire();
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("paused_quiet", int'(outv), 0);
    end
    run = 1'b1;
    @(negedge CLK);
    chk("resume_fetch", int'({ir_load, reset_pc}), 2'b10);
    issue_cls(int'($urandom_range(0, 5)));
    for (int i = 0; i < 4; i++) begin
      wait_fetch();
      issue_cls(int'($urandom_range(0, 5)));
    end

    // Reset during the MEM cycle of a load.
    wait_fetch();
    issue_cls(3);
    repeat (3) @(negedge CLK);
    do_reset();
    repeat (2) @(negedge CLK);
    chk("post_reset_idle", int'(outv), 0);

    for (int k = 0; k < 7; k++) begin
      do_reset();
      start_run();
      for (int i = 0; i < 3; i++) begin
        wait_fetch();
        issue_cls(int'($urandom_range(0, 5)));
      end
      wait_fetch();
      issue_illegal(k);
      check_stuck("trap", 13'h006);
    end

    do_reset();
    start_run();
    for (int i = 0; i < 2; i++) begin
      wait_fetch();
      issue_cls(int'($urandom_range(0, 5)));
    end
    wait_fetch();
    opcode = 7'b1110011;
    funct3 = 3'($urandom);
    funct7 = 7'($urandom);
    check_stuck("halt", 13'h004);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
